// File: rtl/integrator_ctrl.sv
// integrator_ctrl: paces a valid/ready sample stream into the 22-bit integrator at a programmed
// period, drives its enable/clear, captures each result into a one-deep output register.
// Latency: result valid 1 cycle after LOAD entry; in_ready low while the one-entry buffer is full.
module integrator_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic [21:0]      in_data_i,
  output logic             in_ready_o,
  output logic [21:0]      integ_in_o,
  output logic             integ_enable_o,
  output logic             integ_reset_o,
  input  logic [21:0]      integ_out_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [21:0]      out_data_o,
  output logic             busy_o,
  output logic             underrun_o,
  output logic             overrun_o,
  output logic             near_full_o
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WAIT, S_LOAD, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clr_cnt_q, clr_cnt_d;
  logic             clr_idle_q, clr_idle_d;
  logic             stop_pend_q, stop_pend_d;
  logic             buf_full_q, buf_full_d;
  logic [21:0]      buf_q, buf_d;
  logic [21:0]      held_q, held_d;
  logic             out_valid_q, out_valid_d;
  logic [21:0]      out_data_q, out_data_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;
  logic             near_full_q, near_full_d;
  logic             integ_reset_q, integ_enable_q;
  logic [DIV_W-1:0] div_reload;

  // Reload between samples is one less than cfg_div because LOAD and COMMIT already take two
  // cycles; saturating at 0 makes the shortest period LOAD, COMMIT, WAIT(0) = 3 cycles.
  assign div_reload = (cfg_div_i == '0) ? '0 : cfg_div_i - DIV_W'(1);

  assign in_ready_o     = !buf_full_q && (state_q != S_CLEAR);
  assign integ_in_o     = held_q;
  assign integ_enable_o = integ_enable_q;
  assign integ_reset_o  = integ_reset_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign busy_o         = (state_q != S_IDLE);
  assign underrun_o     = underrun_q;
  assign overrun_o      = overrun_q;
  assign near_full_o    = near_full_q;

  // Next-state: command priority clear > stop > start, sample pacing, buffer and capture.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    clr_cnt_d   = clr_cnt_q;
    clr_idle_d  = clr_idle_q;
    stop_pend_d = stop_pend_q;
    buf_full_d  = buf_full_q;
    buf_d       = buf_q;
    held_d      = held_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    near_full_d = near_full_q;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    if (clear_i) begin
      state_d     = S_CLEAR;
      clr_cnt_d   = 1'b0;
      clr_idle_d  = (state_q == S_IDLE) || (state_q == S_CLEAR);
      stop_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_cnt_q) begin
            state_d = clr_idle_q ? S_IDLE : S_WAIT;
            div_d   = div_reload;
          end else begin
            clr_cnt_d = 1'b1;
          end
        end
        S_IDLE: begin
          stop_pend_d = 1'b0;
          if (start_i) begin
            state_d = S_WAIT;
            div_d   = cfg_div_i;
          end
        end
        S_WAIT: begin
          if (stop_i || stop_pend_q) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end else if (div_q == '0) begin
            state_d = S_LOAD;
            // An empty buffer leaves the previous sample in place.
            if (buf_full_q) begin
              held_d     = buf_q;
              buf_full_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            div_d = div_q - DIV_W'(1);
          end
        end
        S_LOAD: begin
          // A stop here waits for COMMIT so the integrator never sees half a sample.
          state_d = S_COMMIT;
          if (stop_i) stop_pend_d = 1'b1;
          out_data_d  = integ_out_i;
          out_valid_d = 1'b1;
          if (out_valid_q && !out_ready_i) overrun_d = 1'b1;
          if (integ_out_i[21] != integ_out_i[20]) near_full_d = 1'b1;
        end
        S_COMMIT: begin
          if (stop_i || stop_pend_q) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_WAIT;
            div_d   = div_reload;
          end
        end
        default: state_d = S_CLEAR;
      endcase
    end

    if (in_valid_i && in_ready_o) begin
      buf_full_d = 1'b1;
      buf_d      = in_data_i;
    end

    // CLEAR flushes everything the integrator result depends on.
    if (state_d == S_CLEAR) begin
      buf_full_d  = 1'b0;
      held_d      = '0;
      out_valid_d = 1'b0;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      near_full_d = 1'b0;
    end
  end

  // State and registered outputs; reset lands in CLEAR so the integrator is cleared too.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_CLEAR;
      div_q          <= '0;
      clr_cnt_q      <= 1'b0;
      clr_idle_q     <= 1'b1;
      stop_pend_q    <= 1'b0;
      buf_full_q     <= 1'b0;
      buf_q          <= '0;
      held_q         <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      near_full_q    <= 1'b0;
      integ_reset_q  <= 1'b1;
      integ_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      clr_cnt_q      <= clr_cnt_d;
      clr_idle_q     <= clr_idle_d;
      stop_pend_q    <= stop_pend_d;
      buf_full_q     <= buf_full_d;
      buf_q          <= buf_d;
      held_q         <= held_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      near_full_q    <= near_full_d;
      integ_reset_q  <= (state_d == S_CLEAR);
      integ_enable_q <= (state_d == S_COMMIT);
    end
  end

endmodule
